// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, one-bit-per-cycle shifts.
// Latency: 1 cycle for non-shift/unsupported/zero-amount shift, s+1 for a shift by s (s capped at WIDTH).
// Backpressure: one command in flight; in_ready low until the result is taken with out_valid && out_ready.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             op_err
);

   localparam int CW  = $clog2(WIDTH + 1);
   localparam int MSB = WIDTH - 1;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;
   localparam logic [5:0] OP_SLT = 6'b101010;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SLL = 6'b000000;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [5:0]       op_q;
   logic [WIDTH-1:0] work;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   dif_ext;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_err;
   logic             is_shift;
   logic [CW-1:0]    shamt;
   logic [WIDTH-1:0] step_res;
   logic             step_bit;

   // Only IDLE accepts, and never while reset is asserted.
   assign in_ready = (state == IDLE) && !reset;

   assign sum_ext = {1'b0, a} + {1'b0, b};
   assign dif_ext = {1'b0, a} - {1'b0, b};

   // Single-cycle result and flags for the op on the input pins at the accept edge.
   always_comb begin
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      alu_err  = 1'b0;
      is_shift = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
         end
         OP_SUB: begin
            alu_res = dif_ext[WIDTH-1:0];
            alu_c   = dif_ext[WIDTH];   // borrow == unsigned a < b
            alu_v   = (a[MSB] != b[MSB]) && (dif_ext[MSB] != a[MSB]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SRL, OP_SRA, OP_SLL: begin
            is_shift = 1'b1;
            alu_res  = a;               // used as-is for a zero-amount shift
         end
         default: alu_err = 1'b1;
      endcase
   end

   // Shift amount saturates at WIDTH; beyond that every bit has been shifted out anyway.
   always_comb begin
      if (b >= WIDTH'(WIDTH)) shamt = CW'(WIDTH);
      else                    shamt = b[CW-1:0];
   end

   // One-bit shift step of the working register and the bit that falls out.
   always_comb begin
      case (op_q)
         OP_SLL: begin
            step_res = {work[WIDTH-2:0], 1'b0};
            step_bit = work[MSB];
         end
         OP_SRA: begin
            step_res = {work[MSB], work[WIDTH-1:1]};
            step_bit = work[0];
         end
         default: begin
            step_res = {1'b0, work[WIDTH-1:1]};
            step_bit = work[0];
         end
      endcase
   end

   // Control FSM with registered result and flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         op_q      <= '0;
         work      <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         op_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q <= op;
                  if (is_shift && (shamt != '0)) begin
                     work  <= a;
                     cnt   <= shamt;
                     state <= SHIFT;
                  end else begin
                     result    <= alu_res;
                     zero      <= (alu_res == '0);
                     negative  <= alu_res[MSB];
                     carry     <= alu_c;
                     overflow  <= alu_v;
                     op_err    <= alu_err;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            SHIFT: begin
               work <= step_res;
               cnt  <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  result    <= step_res;
                  zero      <= (step_res == '0);
                  negative  <= step_res[MSB];
                  carry     <= step_bit;
                  overflow  <= 1'b0;
                  op_err    <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed vector table, random ops against a reference model,
// plus backpressure and reset-during-shift sequences.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge or #1 after rising.
module tb_alu_seq;

   localparam logic [5:0] ADD = 6'b100000;
   localparam logic [5:0] SUB = 6'b100010;
   localparam logic [5:0] AND = 6'b100100;
   localparam logic [5:0] OR  = 6'b100101;
   localparam logic [5:0] XOR = 6'b100110;
   localparam logic [5:0] NOR = 6'b100111;
   localparam logic [5:0] SLT = 6'b101010;
   localparam logic [5:0] SRL = 6'b000010;
   localparam logic [5:0] SRA = 6'b000011;
   localparam logic [5:0] SLL = 6'b000000;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       zero, negative, carry, overflow, op_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       z, n, c, v, err;
      int         lat;
   } vec_t;

   vec_t tbl[$];

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .negative(negative), .carry(carry),
      .overflow(overflow), .op_err(op_err)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] o, input logic [7:0] va, input logic [7:0] vb,
                               input logic [7:0] r, input logic z, input logic n, input logic c,
                               input logic v, input logic e, input int l);
      vec_t t;
      t.op = o; t.a = va; t.b = vb; t.res = r;
      t.z = z; t.n = n; t.c = c; t.v = v; t.err = e; t.lat = l;
      return t;
   endfunction

   // Reference model: direct arithmetic on integers, whole shift in one step.
   function automatic vec_t model(input logic [5:0] o, input logic [7:0] va, input logic [7:0] vb);
      vec_t t;
      int ua, ub, sa, sb, r, s;
      ua = int'(va);
      ub = int'(vb);
      sa = int'($signed(va));
      sb = int'($signed(vb));
      t.op = o; t.a = va; t.b = vb;
      t.c = 1'b0; t.v = 1'b0; t.err = 1'b0; t.lat = 1; t.res = 8'h00;
      s = (ub > 8) ? 8 : ub;
      case (o)
         ADD: begin
            r = ua + ub;
            t.res = r[7:0];
            t.c = (r > 255);
            t.v = ((sa + sb) > 127) || ((sa + sb) < -128);
         end
         SUB: begin
            r = ua - ub;
            t.res = r[7:0];
            t.c = (ua < ub);
            t.v = ((sa - sb) > 127) || ((sa - sb) < -128);
         end
         AND: t.res = va & vb;
         OR:  t.res = va | vb;
         XOR: t.res = va ^ vb;
         NOR: t.res = ~(va | vb);
         SLT: t.res = (sa < sb) ? 8'h01 : 8'h00;
         SRL: begin
            t.res = va >> s;
            t.c = (s > 0) ? va[s-1] : 1'b0;
            t.lat = s + 1;
         end
         SRA: begin
            t.res = 8'($signed(va) >>> s);
            t.c = (s > 0) ? va[s-1] : 1'b0;
            t.lat = s + 1;
         end
         SLL: begin
            t.res = va << s;
            t.c = (s > 0) ? va[8-s] : 1'b0;
            t.lat = s + 1;
         end
         default: t.err = 1'b1;
      endcase
      t.z = (t.res == 8'h00);
      t.n = t.res[7];
      return t;
   endfunction

   // Issue one command from a falling edge while idle, wait for the result, check it,
   // let it be consumed, and return on a falling edge with the block idle again.
   task automatic run_op(input string name, input vec_t v);
      int  lat;
      bit  got;
      bit  rdy_seen;
      check({name, ".in_ready_before"}, 64'(in_ready), 64'(1));
      op = v.op; a = v.a; b = v.b;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 6'($urandom_range(0, 63));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      lat = 0; got = 1'b0; rdy_seen = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            got = 1'b1;
         end
         if (in_ready) rdy_seen = 1'b1;
      end
      check({name, ".latency"}, 64'(lat), 64'(v.lat));
      check({name, ".in_ready_busy"}, 64'(rdy_seen), 64'(0));
      check({name, ".result"}, 64'(result), 64'(v.res));
      check({name, ".flags"}, 64'({zero, negative, carry, overflow, op_err}),
            64'({v.z, v.n, v.c, v.v, v.err}));
      @(posedge clk);
      @(negedge clk);
      check({name, ".idle_after"}, 64'({out_valid, in_ready}), 64'(2'b01));
   endtask

   initial begin
      vec_t v;
      logic [5:0] ops[10];
      bit   rose;
      int   k;

      ops = '{ADD, SUB, AND, OR, XOR, NOR, SLT, SRL, SRA, SLL};

      //        op   a      b      res    z  n  c  v  e  lat
      tbl.push_back(mk(ADD, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(SUB, 8'h05, 8'h07, 8'hFE, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(6'h3F, 8'h05, 8'h07, 8'h00, 1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(SRA, 8'h94, 8'h03, 8'hF2, 0, 1, 1, 0, 0, 4));
      tbl.push_back(mk(SRL, 8'h80, 8'd200, 8'h00, 1, 0, 1, 0, 0, 9));
      tbl.push_back(mk(ADD, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0, 0, 1));
      tbl.push_back(mk(SUB, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1, 0, 1));
      tbl.push_back(mk(SLT, 8'hFE, 8'h01, 8'h01, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(SLT, 8'h01, 8'hFE, 8'h00, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(OR,  8'hF0, 8'h0F, 8'hFF, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(XOR, 8'hAA, 8'hAA, 8'h00, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(NOR, 8'h00, 8'h00, 8'hFF, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(SLL, 8'h81, 8'h01, 8'h02, 0, 0, 1, 0, 0, 2));
      tbl.push_back(mk(SLL, 8'h81, 8'h00, 8'h81, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(SRA, 8'h80, 8'h09, 8'hFF, 0, 1, 1, 0, 0, 9));

      // Reset state
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = 6'h00; a = 8'h00; b = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.outputs", 64'({out_valid, result, zero, negative, carry, overflow, op_err}), 64'(0));
      check("reset.in_ready", 64'(in_ready), 64'(0));
      reset = 1'b0;
      #1;
      check("reset.in_ready_after", 64'(in_ready), 64'(1));

      // Directed vectors
      for (int i = 0; i < tbl.size(); i++) begin
         run_op($sformatf("vec%0d", i), tbl[i]);
      end

      // Random commands against the model
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 10);
         if (k == 10) op = 6'($urandom_range(0, 63));
         else         op = ops[k];
         a = 8'($urandom_range(0, 255));
         if ((op == SRL || op == SRA || op == SLL) && $urandom_range(0, 1) == 1)
            b = 8'($urandom_range(0, 9));
         else
            b = 8'($urandom_range(0, 255));
         v = model(op, a, b);
         run_op($sformatf("rnd%0d", i), v);
      end

      // Backpressure: result held while a new command waits
      out_ready = 1'b0;
      op = ADD; a = 8'h7F; b = 8'h01; in_valid = 1'b1;
      @(posedge clk);
      #1;
      op = ADD; a = 8'h01; b = 8'h02;
      @(negedge clk);
      check("bp.valid", 64'(out_valid), 64'(1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp.hold%0d", i),
               64'({out_valid, in_ready, result, zero, negative, carry, overflow, op_err}),
               64'({1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}));
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp.idle", 64'({out_valid, in_ready}), 64'(2'b01));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp.second", 64'({out_valid, result, overflow}), 64'({1'b1, 8'h03, 1'b0}));
      @(posedge clk);
      @(negedge clk);

      // Reset during the third SHIFT cycle of SLL by 6
      op = SLL; a = 8'hFF; b = 8'h06; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst.in_ready_low", 64'(in_ready), 64'(0));
      @(posedge clk);
      @(negedge clk);
      check("rst.outputs", 64'({out_valid, result, zero, negative, carry, overflow, op_err}), 64'(0));
      reset = 1'b0;
      #1;
      check("rst.in_ready_after", 64'(in_ready), 64'(1));
      rose = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) rose = 1'b1;
      end
      check("rst.no_valid", 64'(rose), 64'(0));
      check("rst.result_zero", 64'(result), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal range 4..64).
REQ-002 Clocking and reset: one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block can accept a command.
REQ-007 op  input  6  operation code (see REQ-014).
REQ-008 a  input  WIDTH  operand A, signed two's complement.
REQ-009 b  input  WIDTH  operand B, signed two's complement; unsigned shift amount for shifts.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero, negative, carry, overflow, op_err  output  1 each  registered status flags.

Function
REQ-014 Op codes (6-bit):
- ADD 100000; SUB 100010; AND 100100; OR 100101; XOR 100110; NOR 100111.
- SLT 101010: result = 1 if signed a < signed b, else 0.
- SRL 000010; SRA 000011; SLL 000000.
- Any other code is unsupported.
REQ-015 FSM states: IDLE, SHIFT, DONE; in_ready = 1 only in IDLE and when reset is low.
REQ-016 Accept: in_valid && in_ready at a rising edge latches op, a and b.
REQ-017 Non-shift, unsupported, or zero-amount shift: result and flags are registered at the accept edge and the FSM goes to DONE; out_valid is high in the following cycle (latency 1).
REQ-018 Shift ops, amount s = min(unsigned b, WIDTH):
- Accept edge loads the working register with a and a counter with s, then enters SHIFT.
- Each SHIFT edge shifts by one bit and decrements the counter.
- The edge at which the counter reaches 0 enters DONE; latency is s+1 cycles.
REQ-019 Shift fill: SRL and SLL fill with 0; SRA fills with a[WIDTH-1].
- b >= WIDTH gives all-zero (SRL/SLL) or all-sign (SRA) after exactly WIDTH iterations.
REQ-020 Arithmetic is modulo 2^WIDTH.
- ADD: carry = unsigned carry-out.
- SUB: carry = borrow, i.e. unsigned a < unsigned b.
- overflow = signed overflow for ADD/SUB only, 0 for all other ops.
REQ-021 Shift carry = last bit shifted out; 0 when s = 0. carry = 0 for logic ops and SLT.
REQ-022 zero = (result == 0) and negative = result[WIDTH-1], for every op.
REQ-023 Unsupported op: result = 0, op_err = 1, zero = 1, all other flags 0, latency 1.
- op_err = 0 for every supported op.
REQ-024 DONE:
- out_valid = 1; result and flags hold stable until out_valid && out_ready.
- On that edge the FSM returns to IDLE; out_valid is low the next cycle.
REQ-025 in_valid is ignored outside IDLE; commands presented then are not latched or queued.
- No accept and completion can occur on the same edge.
REQ-026 Input changes on a, b and op after the accept edge do not affect an operation in progress.

Reset
REQ-027 While reset is high at an edge:
- FSM goes to IDLE; counter and working register clear.
- out_valid = 0; result = 0; all flags = 0.
REQ-028 in_ready = 0 in any cycle where reset is high; it is 1 from the first cycle after reset deasserts.
REQ-029 Reset in SHIFT or DONE abandons the operation; no out_valid is produced for it.

Verification (WIDTH = 8)
REQ-030 ADD a=0x7F b=0x01, out_ready=1 -> next cycle: out_valid=1, result=0x80, overflow=1, negative=1, carry=0, zero=0.
REQ-031 SUB a=0x05 b=0x07 -> result=0xFE, carry=1, negative=1, overflow=0; then op=0x3F -> result=0x00, op_err=1, zero=1.
REQ-032 SRA a=0x94 b=3 -> out_valid 4 cycles after accept, result=0xF2, carry=1, in_ready=0 throughout.
REQ-033 SRL a=0x80 b=200 -> out_valid 9 cycles after accept, result=0x00, zero=1, carry=1.
REQ-034 Backpressure: out_ready=0 for 5 cycles while in_valid=1 with new operands.
- result and flags stay unchanged; no accept occurs.
- out_ready=1 -> IDLE next cycle, then the waiting command is accepted.
REQ-035 Reset mid-SHIFT (SLL b=6, reset at the 3rd SHIFT cycle) -> out_valid never rises, all outputs 0, in_ready=1 the cycle after reset falls.
